// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 input padder.
package sha256_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    PAD,
    ZERO,
    LENHI,
    LENLO,
    DONE
  } state_t;

  localparam int SHA256_BLK_WORDS = 16;
  localparam int SHA256_LEN_IDX   = 14;
  localparam int SHA256_IDX_W     = $clog2(SHA256_BLK_WORDS);

  localparam logic [31:0] SHA256_PAD_WORD = 32'h80000000;

endpackage

// File: rtl/sha256_pad_mask.sv
// Last-word masking: keeps the first n bytes, places 0x80 in byte n, clears the rest.
module sha256_pad_mask (
  input  logic [31:0] data,
  input  logic [2:0]  n,
  output logic [31:0] masked
);

  // n of 4 or more means the whole word is message data
  always_comb begin
    masked = data;
    case (n)
      3'd0:    masked = {8'h80, 24'h000000};
      3'd1:    masked = {data[31:24], 8'h80, 16'h0000};
      3'd2:    masked = {data[31:16], 8'h80, 8'h00};
      3'd3:    masked = {data[31:8], 8'h80};
      default: masked = data;
    endcase
  end

endmodule

// File: rtl/sha256_padder.sv
// SHA-256 message padder feeding the engine's input FIFO with whole 512-bit blocks.
// Optional block counter enabled by defining SHA256_PADDER_STAT_EN.
module sha256_padder
  import sha256_pkg::*;
#(
  parameter int LEN_W = 64
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start_i,
  input  logic        msg_vld_i,
  output logic        msg_rdy_o,
  input  logic [31:0] msg_dat_i,
  input  logic        msg_last_i,
  input  logic [2:0]  msg_bytes_i,
  input  logic        fifo_afull_i,
  output logic        fifo_wr_en_o,
  output logic [31:0] fifo_wr_dat_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] blk_cnt_o
);

  state_t                  state, state_n;
  logic [SHA256_IDX_W-1:0] idx, idx_n;
  logic [LEN_W-1:0]        bitlen, bitlen_n;
  logic                    wr_en_n;
  logic [31:0]             wr_dat_n;
  logic                    busy_n;
  logic                    done_n;
  logic [31:0]             masked;
  logic [63:0]             len64;
  logic                    can_write;

  sha256_pad_mask u_mask (
    .data   (msg_dat_i),
    .n      (msg_bytes_i),
    .masked (masked)
  );

  assign len64     = 64'(bitlen);
  assign can_write = !fifo_afull_i;
  assign msg_rdy_o = (state == DATA) && can_write;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= IDLE;
      idx           <= '0;
      bitlen        <= '0;
      fifo_wr_en_o  <= 1'b0;
      fifo_wr_dat_o <= 32'h0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
    end else begin
      state         <= state_n;
      idx           <= idx_n;
      bitlen        <= bitlen_n;
      fifo_wr_en_o  <= wr_en_n;
      fifo_wr_dat_o <= wr_dat_n;
      busy_o        <= busy_n;
      done_o        <= done_n;
    end
  end

  always_comb begin
    state_n  = state;
    idx_n    = idx;
    bitlen_n = bitlen;
    wr_en_n  = 1'b0;
    wr_dat_n = fifo_wr_dat_o;
    busy_n   = busy_o;
    done_n   = 1'b0;

    case (state)
      IDLE: begin
        if (start_i) begin
          bitlen_n = '0;
          idx_n    = '0;
          busy_n   = 1'b1;
          state_n  = DATA;
        end
      end

      DATA: begin
        if (msg_vld_i && can_write) begin
          wr_en_n = 1'b1;
          idx_n   = idx + 1'b1;
          if (!msg_last_i || msg_bytes_i[2]) begin
            wr_dat_n = msg_dat_i;
            bitlen_n = bitlen + LEN_W'(32);
            if (msg_last_i) begin
              state_n = PAD;
            end
          end else begin
            wr_dat_n = masked;
            bitlen_n = bitlen + LEN_W'({msg_bytes_i, 3'b000});
            state_n  = ZERO;
          end
        end
      end

      PAD: begin
        if (can_write) begin
          wr_en_n  = 1'b1;
          wr_dat_n = SHA256_PAD_WORD;
          idx_n    = idx + 1'b1;
          state_n  = ZERO;
        end
      end

      // The length slot check needs no FIFO space since nothing is written
      ZERO: begin
        if (idx == SHA256_IDX_W'(SHA256_LEN_IDX)) begin
          state_n = LENHI;
        end else if (can_write) begin
          wr_en_n  = 1'b1;
          wr_dat_n = 32'h0;
          idx_n    = idx + 1'b1;
        end
      end

      LENHI: begin
        if (can_write) begin
          wr_en_n  = 1'b1;
          wr_dat_n = len64[63:32];
          idx_n    = idx + 1'b1;
          state_n  = LENLO;
        end
      end

      LENLO: begin
        if (can_write) begin
          wr_en_n  = 1'b1;
          wr_dat_n = len64[31:0];
          idx_n    = idx + 1'b1;
          done_n   = 1'b1;
          busy_n   = 1'b0;
          state_n  = DONE;
        end
      end

      DONE: begin
        state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

`ifdef SHA256_PADDER_STAT_EN
  logic [31:0] blk_cnt;

  // A write into the final slot completes one 512-bit block
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      blk_cnt <= 32'h0;
    end else if (wr_en_n && (idx == '1) && (blk_cnt != 32'hFFFFFFFF)) begin
      blk_cnt <= blk_cnt + 32'h1;
    end
  end

  assign blk_cnt_o = blk_cnt;
`else
  assign blk_cnt_o = 32'h0;
`endif

endmodule

// File: doc/sha256_padder.md
Name: sha256_padder

Overview:
- Writer side of the SHA-256 input FIFO.
- Accepts a raw big-endian message as 32-bit words with a last-word byte count.
- Appends the FIPS 180-4 padding: a 0x80 byte, zero fill, then the 64-bit bit length.
- Pushes complete 512-bit blocks (16 words each) into the FIFO that sha256_engine drains.

Parameters:
- LEN_W, 64, width of the internal bit-length counter (2..64). Bits at and above LEN_W are emitted as zero in the length field.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- start_i  in  1  pulse; begins a new message; ignored unless in IDLE
- msg_vld_i  in  1  message word valid
- msg_rdy_o  out  1  padder accepts word this cycle
- msg_dat_i  in  32  message word; first byte in [31:24]
- msg_last_i  in  1  this word is the last word of the message
- msg_bytes_i  in  3  valid bytes in the last word, 0..4; values 5..7 are treated as 4; ignored when not last
- fifo_afull_i  in  1  FIFO almost-full; asserted with at least 1 free entry remaining
- fifo_wr_en_o  out  1  FIFO write strobe, registered
- fifo_wr_dat_o  out  32  FIFO write data, registered
- busy_o  out  1  high from start accept until done
- done_o  out  1  1-cycle pulse after the final length word is written
- blk_cnt_o  out  32  blocks emitted (see Optional Feature)

Behaviour:
- Reset values: msg_rdy_o=0, fifo_wr_en_o=0, fifo_wr_dat_o=0, busy_o=0, done_o=0, blk_cnt_o=0; state=IDLE; idx=0; bitlen=0.
- Async reset mid-message returns to IDLE immediately. The FIFO must be reset together with the padder; partial blocks are discarded by the system.
- Slot advance (every state below): a word is written only in a cycle with fifo_afull_i=0. In that case fifo_wr_en_o=1 and fifo_wr_dat_o=word on the next edge, and idx (4 bit) increments mod 16. Otherwise fifo_wr_en_o=0 and the state holds.
- States:
  - IDLE: on start_i: bitlen=0, idx=0, busy_o=1, go to DATA. msg_rdy_o=0.
  - DATA: msg_rdy_o = !fifo_afull_i (combinational).
    - Accepted non-last word: write it; bitlen += 32.
    - Accepted last word, n = min(msg_bytes_i, 4):
      - n=4: write it; bitlen += 32; go to PAD.
      - n<4: write the data with bytes ≥n cleared and byte n = 0x80; bitlen += 8n; go to ZERO.
  - PAD: write 0x80000000; go to ZERO.
  - ZERO: if idx==14 go to LENHI (no write this cycle); else write 0x00000000.
  - LENHI: write bitlen[63:32]; go to LENLO.
  - LENLO: write bitlen[31:0]; go to DONE.
  - DONE: done_o=1 for one cycle, busy_o=0, go to IDLE.
- Padding invariant: when the 0x80 word lands at idx 14 or 15, ZERO fills through the end of that block and through idx 13 of the next block. Total words emitted is always a multiple of 16.
- bitlen arithmetic: unsigned, wraps modulo 2^LEN_W.
- msg_vld_i outside DATA is ignored. start_i outside IDLE is ignored.
- A fifo_afull_i rise exactly on a write cycle is safe because of the required 1-entry margin.

Optional Feature:
- Macro: SHA256_PADDER_STAT_EN.
  - Defined: blk_cnt_o increments when a word is written at idx 15. It is cleared only by reset and saturates at 0xFFFFFFFF.
  - Undefined: blk_cnt_o is tied to 0 and no counter logic exists.

Decomposition:
- sha256_pkg holds:
  - state enum type: IDLE, DATA, PAD, ZERO, LENHI, LENLO, DONE
  - SHA256_BLK_WORDS = 16
  - SHA256_LEN_IDX = 14
  - SHA256_PAD_WORD = 32'h80000000
- One sub-module, sha256_pad_mask: combinational last-word masking and 0x80 insertion from (data, n).

Test Plan:
- "abc" (1 word 0x61626300, last, bytes=3) -> 16 writes: 0x61626380, 14×0x00000000, 0x00000018; blk_cnt_o=1.
- Empty message (word ignored, last, bytes=0) -> 0x80000000, 14×0, 0x00000000 at idx15 (length 0); done_o pulses once.
- 56-byte message (14 full words, the last with bytes=4) -> data at idx 0..13, 0x80000000 at idx14, 0 at idx15, 14 zeros, 0x00000000, 0x000001C0. 32 writes; blk_cnt_o=2.
- 55-byte message (last word bytes=3 at idx13) -> idx13 = data|0x00000080, idx14 = 0, idx15 = 0x000001B8. 16 writes total.
- Backpressure: toggle fifo_afull_i randomly on "abc" -> no write while afull is sampled high, identical 16-word sequence, msg_rdy_o=0 whenever fifo_afull_i=1.
- Reset mid-ZERO (after 5 writes): rstn low for 1 cycle -> all outputs 0 asynchronously, state IDLE. A fresh start_i with "abc" then reproduces the first scenario exactly.
